// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID read-port bundle for the register file.
// The master side (pipeline) drives write-back controls/data and read addresses;
// the slave side (register file) returns read data, the muxed write value and
// the commit status.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              WB_RegWrite;
  logic              WB_MemToReg;
  logic [DATA_W-1:0] WB_ALUOut;
  logic [DATA_W-1:0] WB_ReadMemData;
  logic [ADDR_W-1:0] WB_WriteRegAddr;
  logic [ADDR_W-1:0] ID_ReadAddr1;
  logic [ADDR_W-1:0] ID_ReadAddr2;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;
  logic [DATA_W-1:0] WB_WriteData;
  logic              WB_Commit;
  logic [CNT_W-1:0]  CommitCount;

  modport master (
    output WB_RegWrite, WB_MemToReg, WB_ALUOut, WB_ReadMemData, WB_WriteRegAddr,
    output ID_ReadAddr1, ID_ReadAddr2,
    input  ID_ReadData1, ID_ReadData2, WB_WriteData, WB_Commit, CommitCount
  );

  modport slave (
    input  WB_RegWrite, WB_MemToReg, WB_ALUOut, WB_ReadMemData, WB_WriteRegAddr,
    input  ID_ReadAddr1, ID_ReadAddr2,
    output ID_ReadData1, ID_ReadData2, WB_WriteData, WB_Commit, CommitCount
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it to
// a 2^ADDR_W x DATA_W register file (register 0 hard-wired to zero), serves two
// combinational read ports with same-cycle write-through, and counts commits.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic          Clk,
  input logic          Rst,
  wb_regfile_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Register 0 has no storage; entries 1..Depth-1 only.
  logic [DATA_W-1:0] regs_q [1:Depth-1];

  logic              commit;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              commit_q;
  logic [CNT_W-1:0]  commit_count_q;
  logic [CNT_W-1:0]  commit_count_d;

  // Write-back source select, independent of the write enable.
  always_comb begin
    write_data = bus.WB_MemToReg ? bus.WB_ReadMemData : bus.WB_ALUOut;
  end

  // A write takes effect only when enabled, aimed at a real register and not in reset.
  always_comb begin
    commit = bus.WB_RegWrite && (bus.WB_WriteRegAddr != '0) && !Rst;
  end

  // Register storage: synchronous clear, otherwise commit the selected value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 1; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[bus.WB_WriteRegAddr] <= write_data;
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then storage.
  always_comb begin
    read_data1 = '0;
    if (bus.ID_ReadAddr1 == '0) begin
      read_data1 = '0;
    end else if (commit && (bus.ID_ReadAddr1 == bus.WB_WriteRegAddr)) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs_q[bus.ID_ReadAddr1];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    read_data2 = '0;
    if (bus.ID_ReadAddr2 == '0) begin
      read_data2 = '0;
    end else if (commit && (bus.ID_ReadAddr2 == bus.WB_WriteRegAddr)) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs_q[bus.ID_ReadAddr2];
    end
  end

  // Commit counter next state; wraps naturally at 2^CNT_W.
  always_comb begin
    commit_count_d = commit_count_q;
    if (commit) begin
      commit_count_d = commit_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Commit flag and counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      commit_q       <= 1'b0;
      commit_count_q <= '0;
    end else begin
      commit_q       <= commit;
      commit_count_q <= commit_count_d;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.WB_WriteData = write_data;
    bus.ID_ReadData1 = read_data1;
    bus.ID_ReadData2 = read_data2;
    bus.WB_Commit    = commit_q;
    bus.CommitCount  = commit_count_q;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface.
- Consumes the registered WB-stage control and data signals.
- Selects the write-back value (ALU result or memory load data) and commits it to the 32x32 general-purpose register file.
- Provides two read ports to the ID stage, with same-cycle write-through bypass, and maintains a committed-write counter for debug.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; depth is 2^ADDR_W.
- CNT_W, 32, width of the committed-write counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- WB_RegWrite  input  1  write enable from MEM/WB register.
- WB_MemToReg  input  1  1 = write WB_ReadMemData, 0 = write WB_ALUOut.
- WB_ALUOut  input  DATA_W  ALU result.
- WB_ReadMemData  input  DATA_W  load data.
- WB_WriteRegAddr  input  ADDR_W  destination register.
- ID_ReadAddr1  input  ADDR_W  read port 1 address (rs).
- ID_ReadAddr2  input  ADDR_W  read port 2 address (rt).
- ID_ReadData1  output  DATA_W  read port 1 data, combinational.
- ID_ReadData2  output  DATA_W  read port 2 data, combinational.
- WB_WriteData  output  DATA_W  selected write-back value, combinational.
- WB_Commit  output  1  registered; high for the cycle after a write is committed.
- CommitCount  output  CNT_W  registered count of committed writes.

Behaviour:
- Write-data mux:
  - WB_WriteData = WB_MemToReg ? WB_ReadMemData : WB_ALUOut.
  - Always driven, independent of WB_RegWrite.
- Commit condition:
  - commit = WB_RegWrite && (WB_WriteRegAddr != 0) && !Rst.
  - On a rising edge with commit, regs[WB_WriteRegAddr] <= WB_WriteData.
- Register 0:
  - Never written; always reads 0.
  - A write to address 0 is silently dropped and does not count as a commit.
- Read ports (combinational, each port evaluated independently):
  - addr == 0 -> 0.
  - Otherwise, if commit && addr == WB_WriteRegAddr -> WB_WriteData (bypass).
  - Otherwise -> regs[addr].
  - Bypass removes the WB->ID hazard; no extra stall is required.
- Both read ports addressing the same register return identical data, including under bypass.
- Counter and commit flag:
  - On each edge, WB_Commit <= commit.
  - If commit, CommitCount <= CommitCount + 1.
  - CommitCount wraps modulo 2^CNT_W with no saturation and no flag.
- Reset:
  - When Rst is high at a rising edge, all regs[1..31] <= 0, WB_Commit <= 0, CommitCount <= 0.
  - Any coincident write is discarded; reset wins.
  - While Rst is high, bypass is disabled (commit = 0), so reads return stored values, i.e. 0 after the first reset edge.
  - Reset asserted mid-stream discards the in-flight write; the first commit after Rst deasserts counts from 0.
- Latency:
  - A write is visible on the read ports in the same cycle via bypass, and from storage on every following cycle.
  - WB_Commit and CommitCount reflect a commit one cycle after it.
- Undefined values: X on WB_* inputs while WB_RegWrite = 0 must not corrupt state.

Test Plan:
- Reset: hold Rst 2 cycles, then read all 32 addresses on both ports -> every read = 0x00000000; CommitCount = 0; WB_Commit = 0.
- ALU write-back:
  - Stimulus: RegWrite = 1, MemToReg = 0, ALUOut = 0x12345678, addr = 5, with ReadAddr1 = 5 in the same cycle.
  - Response: ReadData1 = 0x12345678 that cycle (bypass) and on later cycles; WB_Commit = 1 next cycle; CommitCount = 1.
- Load write-back:
  - Stimulus: MemToReg = 1, ReadMemData = 0xDEADBEEF, ALUOut = 0x11111111, addr = 31, then read addr 31 on both ports.
  - Response: both ports = 0xDEADBEEF; WB_WriteData = 0xDEADBEEF during the write cycle.
- Register 0 protection:
  - Stimulus: RegWrite = 1, addr = 0, ALUOut = 0xFFFFFFFF, with ReadAddr2 = 0.
  - Response: ReadData2 = 0 in the same and next cycle; WB_Commit stays 0; CommitCount unchanged.
- RegWrite low and counter wrap:
  - RegWrite = 0, addr = 7, ALUOut = 0xAAAA5555 -> reg 7 unchanged (0); CommitCount unchanged.
  - Separately, with CNT_W = 4, perform 17 commits -> CommitCount = 1.
- Reset mid-operation:
  - Stimulus: write 0x55 to reg 3; next cycle assert Rst together with RegWrite = 1, addr = 4, data = 0x66; deassert Rst.
  - Response: reg 3 = 0, reg 4 = 0; bypass on addr 4 during the Rst cycle returns stored 0x00000000, not 0x66; CommitCount = 0.
